cmd_exec: RTL and testbench

- Downstream consumer of the command-memory writer (wcm).
- Captures each command presented on DATA_WR and waits until system TIME reaches TIME_START. It then plays out the command as Tblank1 → N×(pulse Ti, pause Tp) → Tblank2, drives the NCO frequency word, and raises REQ_COMM to ask wcm for the next command.
- Holds one active command plus one pending command.

---
 rtl/cmd_exec_pkg.sv | 45 ++++
 rtl/cmd_exec_nco.sv | 100 ++++++++++
 rtl/cmd_exec.sv | 171 +++++++++++++++++
 tb/tb_cmd_exec.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cmd_exec_pkg.sv
// cmd_exec_pkg: shared types for the command executor.
// Holds the FSM state enum, the pulse-type codes, the captured command
// record (wcm field order, 338 bits) and a helper giving each timed state
// its length.
package cmd_exec_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ARMED,
      S_BLANK1,
      S_PULSE,
      S_PAUSE,
      S_BLANK2,
      S_DONE
   } exec_state_t;

   localparam logic [1:0] TYPE_CONST = 2'd0;
   localparam logic [1:0] TYPE_SWEEP = 2'd1;
   localparam logic [1:0] TYPE_STEP  = 2'd2;

   typedef struct packed {
      logic [47:0] freq;
      logic [47:0] freq_step;
      logic [31:0] freq_rate;
      logic [63:0] time_start;
      logic [15:0] n_impuls;
      logic [1:0]  type_impulse;
      logic [31:0] ti;
      logic [31:0] tp;
      logic [31:0] tblank1;
      logic [31:0] tblank2;
   } cmd_t;

   // Length in clocks of a timed state; untimed states report 0.
   function automatic logic [31:0] state_len(input exec_state_t s, input cmd_t c);
      case (s)
         S_BLANK1: return c.tblank1;
         S_PULSE:  return c.ti;
         S_PAUSE:  return c.tp;
         S_BLANK2: return c.tblank2;
         default:  return 32'd0;
      endcase
   endfunction

endpackage

// File: rtl/cmd_exec_nco.sv
// cmd_exec_nco: frequency word generation for cmd_exec.
// Loads the start frequency when a command begins, applies the per-pulse
// step (type 2) or the in-pulse linear sweep (type 1) and strobes
// nco_update whenever the word is (re)loaded or changes.
// Build option: CMD_EXEC_SWEEP_EN builds the type 1 sweep; without it type 1
// behaves like the constant type.
module cmd_exec_nco
   import cmd_exec_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        abort,
   input  logic        start,
   input  logic        pulse_enter,
   input  logic        in_pulse,
   input  logic [1:0]  typ,
   input  logic [47:0] freq,
   input  logic [47:0] step,
   input  logic [31:0] rate,
   output logic [47:0] nco_freq,
   output logic        nco_update
);

   logic [47:0] acc;
   logic [47:0] acc_nxt;
   logic [47:0] freq_nxt;
   logic        upd_nxt;
`ifdef CMD_EXEC_SWEEP_EN
   logic [31:0] rate_cnt;
   logic [31:0] rate_nxt;
`else
   logic        unused_sweep;
   assign unused_sweep = ^{in_pulse, rate};
`endif

   // Next frequency word: start load, per-pulse reload/step, in-pulse sweep
   always_comb begin
      // NOTE: every output of this block gets a default first, so no path leaves a value unassigned and no latch is inferred.
      freq_nxt = nco_freq;
      acc_nxt  = acc;
      upd_nxt  = 1'b0;
`ifdef CMD_EXEC_SWEEP_EN
      rate_nxt = rate_cnt;
`endif
      if (!abort) begin
         if (start) begin
            freq_nxt = freq;
            acc_nxt  = (pulse_enter && typ == TYPE_STEP) ? freq + step : freq;
            upd_nxt  = 1'b1;
`ifdef CMD_EXEC_SWEEP_EN
            rate_nxt = 32'd0;
`endif
         end else if (pulse_enter) begin
            if (typ == TYPE_STEP) begin
               freq_nxt = acc;
               acc_nxt  = acc + step;
            end
`ifdef CMD_EXEC_SWEEP_EN
            else if (typ == TYPE_SWEEP) begin
               freq_nxt = freq;
            end
            rate_nxt = 32'd0;
`endif
            upd_nxt = (freq_nxt != nco_freq);
         end
`ifdef CMD_EXEC_SWEEP_EN
         else if (in_pulse && typ == TYPE_SWEEP && rate != 32'd0) begin
            if (rate_cnt == rate - 32'd1) begin
               rate_nxt = 32'd0;
               freq_nxt = nco_freq + step;
               upd_nxt  = (step != 48'd0);
            end else begin
               rate_nxt = rate_cnt + 32'd1;
            end
         end
`endif
      end
   end

   // Frequency word, step accumulator and update strobe registers
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: non-blocking assignments make every flop here update from pre-edge values, independent of statement order.
      if (!rst_n) begin
         nco_freq   <= 48'd0;
         acc        <= 48'd0;
         nco_update <= 1'b0;
`ifdef CMD_EXEC_SWEEP_EN
         rate_cnt   <= 32'd0;
`endif
      end else begin
         nco_freq   <= freq_nxt;
         acc        <= acc_nxt;
         nco_update <= upd_nxt;
`ifdef CMD_EXEC_SWEEP_EN
         rate_cnt   <= rate_nxt;
`endif
      end
   end

endmodule

// File: rtl/cmd_exec.sv
// cmd_exec: timed command executor downstream of wcm.
// Captures commands into a one-deep pending slot, waits for TIME_START,
// plays Tblank1 -> N x (Ti pulse, Tp pause) -> Tblank2 and requests the next
// command with a REQ_LEN-clock REQ_COMM pulse.
// Build option: CMD_EXEC_SWEEP_EN enables the type 1 linear sweep in
// cmd_exec_nco.
module cmd_exec
   import cmd_exec_pkg::*;
#(
   parameter int REQ_LEN = 4,
   parameter int TW      = 64
) (
   input  logic          CLK,
   input  logic          rst_n,
   input  logic [TW-1:0] TIME,
   input  logic          ABORT,
   input  logic          DATA_WR,
   input  logic [47:0]   FREQ_z,
   input  logic [47:0]   FREQ_STEP_z,
   input  logic [31:0]   FREQ_RATE_z,
   input  logic [TW-1:0] TIME_START_z,
   input  logic [15:0]   N_impuls_z,
   input  logic [1:0]    TYPE_impulse_z,
   input  logic [31:0]   Interval_Ti_z,
   input  logic [31:0]   Interval_Tp_z,
   input  logic [31:0]   Tblank1_z,
   input  logic [31:0]   Tblank2_z,
   output logic          REQ_COMM,
   output logic          IMPULSE,
   output logic          BLANK,
   output logic [47:0]   NCO_FREQ,
   output logic          NCO_UPDATE,
   output logic          BUSY,
   output logic          ERR_LATE,
   output logic          OVERRUN
);

   localparam int RW = $clog2(REQ_LEN + 1);

   exec_state_t   state, nxt_state;
   exec_state_t   after_armed, after_blank1, after_pulses;
   cmd_t          fields, pend, act;
   logic          pend_valid, data_wr_q, first_armed, primed;
   logic [31:0]   cnt, cnt_nxt;
   logic [15:0]   pulse_cnt, pulse_cnt_nxt, pulse_done;
   logic [RW-1:0] req_cnt;
   logic          capture, take, enter, late, go, pulse_enter;

   assign fields = {FREQ_z, FREQ_STEP_z, FREQ_RATE_z, TIME_START_z, N_impuls_z,
                    TYPE_impulse_z, Interval_Ti_z, Interval_Tp_z, Tblank1_z, Tblank2_z};

   assign capture     = DATA_WR && !data_wr_q && !ABORT;
   assign take        = (state == S_IDLE) && pend_valid && !ABORT;
   assign pulse_done  = pulse_cnt + 16'd1;
   assign pulse_enter = enter && (nxt_state == S_PULSE);

   assign REQ_COMM = (req_cnt != '0);
   assign IMPULSE  = (state == S_PULSE);
   assign BLANK    = (state == S_BLANK1) || (state == S_BLANK2);
   assign BUSY     = (state != S_IDLE);

   // Successor of each phase, skipping phases whose length is zero
   always_comb begin
      after_pulses = (act.tblank2 != 32'd0) ? S_BLANK2 : S_DONE;
      after_blank1 = (act.n_impuls != 16'd0 && act.ti != 32'd0) ? S_PULSE : after_pulses;
      after_armed  = (act.tblank1 != 32'd0) ? S_BLANK1 : after_blank1;
   end

   // Next-state, down-counter and pulse-counter logic
   always_comb begin
      nxt_state     = state;
      cnt_nxt       = cnt;
      pulse_cnt_nxt = pulse_cnt;
      enter         = 1'b0;
      late          = 1'b0;
      go            = 1'b0;
      case (state)
         S_IDLE: begin
            if (pend_valid) nxt_state = S_ARMED;
         end
         S_ARMED: begin
            pulse_cnt_nxt = 16'd0;
            if (first_armed && act.time_start <= TIME) begin
               late      = 1'b1;
               nxt_state = S_DONE;
            end else if (TIME >= act.time_start) begin
               go        = 1'b1;
               enter     = 1'b1;
               nxt_state = after_armed;
            end
         end
         S_BLANK1, S_PAUSE, S_BLANK2: begin
            if (cnt == 32'd0) begin
               enter     = 1'b1;
               nxt_state = (state == S_BLANK1) ? after_blank1 :
                           (state == S_PAUSE)  ? S_PULSE : S_DONE;
            end else begin
               cnt_nxt = cnt - 32'd1;
            end
         end
         S_PULSE: begin
            if (cnt == 32'd0) begin
               enter         = 1'b1;
               pulse_cnt_nxt = pulse_done;
               if (pulse_done == act.n_impuls) nxt_state = after_pulses;
               else if (act.tp != 32'd0)       nxt_state = S_PAUSE;
               else                            nxt_state = S_PULSE;
            end else begin
               cnt_nxt = cnt - 32'd1;
            end
         end
         S_DONE:  nxt_state = S_IDLE;
         default: nxt_state = S_IDLE;
      endcase
      if (enter) cnt_nxt = state_len(nxt_state, act) - 32'd1;
      if (ABORT) nxt_state = S_IDLE;
   end

   // Control state, pending flag, request timer and status pulses
   always_ff @(posedge CLK or negedge rst_n) begin
      if (!rst_n) begin
         state       <= S_IDLE;
         cnt         <= 32'd0;
         pulse_cnt   <= 16'd0;
         first_armed <= 1'b0;
         data_wr_q   <= 1'b0;
         pend_valid  <= 1'b0;
         primed      <= 1'b0;
         req_cnt     <= '0;
         ERR_LATE    <= 1'b0;
         OVERRUN     <= 1'b0;
      end else begin
         state       <= nxt_state;
         cnt         <= cnt_nxt;
         pulse_cnt   <= pulse_cnt_nxt;
         first_armed <= take;
         data_wr_q   <= DATA_WR;
         primed      <= 1'b1;
         ERR_LATE    <= late && !ABORT;
         OVERRUN     <= capture && pend_valid && !take;
         if (ABORT)        pend_valid <= 1'b0;
         else if (capture) pend_valid <= 1'b1;
         else if (take)    pend_valid <= 1'b0;
         if (!primed || ABORT || state == S_DONE) req_cnt <= RW'(REQ_LEN);
         else if (req_cnt != '0)                  req_cnt <= req_cnt - RW'(1);
      end
   end

   // Command payload: pending slot and active command
   always_ff @(posedge CLK) begin
      // NOTE: the wide payload registers carry no reset; pend_valid and the state machine gate every use of their contents.
      if (capture) pend <= fields;
      if (take)    act  <= pend;
   end

   cmd_exec_nco u_nco (
      .clk        (CLK),
      .rst_n      (rst_n),
      .abort      (ABORT),
      .start      (go && !ABORT),
      .pulse_enter(pulse_enter),
      .in_pulse   (state == S_PULSE),
      .typ        (act.type_impulse),
      .freq       (act.freq),
      .step       (act.freq_step),
      .rate       (act.freq_rate),
      .nco_freq   (NCO_FREQ),
      .nco_update (NCO_UPDATE)
   );

endmodule

// File: tb/tb_cmd_exec.sv
// tb_cmd_exec: directed self-checking bench for cmd_exec.
// Expected values are hand-computed from the command timing; statistics of
// every sampled cycle are gathered in cyc() and compared per scenario.
// Honours CMD_EXEC_SWEEP_EN for the type 1 sweep scenario.
module tb_cmd_exec;
   import cmd_exec_pkg::*;

   logic        clk;
   logic        rst_n;
   logic [63:0] time_r;
   logic        abort;
   logic        data_wr;
   cmd_t        cmd;

   logic        REQ_COMM, IMPULSE, BLANK, NCO_UPDATE, BUSY, ERR_LATE, OVERRUN;
   logic [47:0] NCO_FREQ;

   int tests = 0;
   int fails = 0;

   // per-scenario statistics
   int          n_imp, n_blk, n_req, n_late, n_ovr, n_upd, n_rise, n_fall;
   logic [63:0] first_blank_t, req_first_t;
   logic [63:0] rise_t [4];
   logic [63:0] fall_t [4];
   logic [47:0] rise_f [4];
   logic [47:0] fall_f [4];
   logic [47:0] last_f [4];
   logic        seen_busy, got_blank, got_req;
   logic        imp_q, blk_q, req_q;
   logic [47:0] prev_f;

   cmd_exec #(.REQ_LEN(4), .TW(64)) dut (
      .CLK           (clk),
      .rst_n         (rst_n),
      .TIME          (time_r),
      .ABORT         (abort),
      .DATA_WR       (data_wr),
      .FREQ_z        (cmd.freq),
      .FREQ_STEP_z   (cmd.freq_step),
      .FREQ_RATE_z   (cmd.freq_rate),
      .TIME_START_z  (cmd.time_start),
      .N_impuls_z    (cmd.n_impuls),
      .TYPE_impulse_z(cmd.type_impulse),
      .Interval_Ti_z (cmd.ti),
      .Interval_Tp_z (cmd.tp),
      .Tblank1_z     (cmd.tblank1),
      .Tblank2_z     (cmd.tblank2),
      .REQ_COMM      (REQ_COMM),
      .IMPULSE       (IMPULSE),
      .BLANK         (BLANK),
      .NCO_FREQ      (NCO_FREQ),
      .NCO_UPDATE    (NCO_UPDATE),
      .BUSY          (BUSY),
      .ERR_LATE      (ERR_LATE),
      .OVERRUN       (OVERRUN)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   function automatic cmd_t mk(input logic [47:0] freq, input logic [47:0] step,
                               input logic [31:0] rate, input logic [63:0] tstart,
                               input logic [15:0] n, input logic [1:0] typ,
                               input logic [31:0] ti, input logic [31:0] tp,
                               input logic [31:0] tb1, input logic [31:0] tb2);
      cmd_t c;
      c.freq = freq;       c.freq_step = step;  c.freq_rate = rate;
      c.time_start = tstart; c.n_impuls = n;    c.type_impulse = typ;
      c.ti = ti;           c.tp = tp;           c.tblank1 = tb1;
      c.tblank2 = tb2;
      return c;
   endfunction

   task automatic clear_stats();
      n_imp = 0; n_blk = 0; n_req = 0; n_late = 0; n_ovr = 0; n_upd = 0;
      n_rise = 0; n_fall = 0; first_blank_t = 0; req_first_t = 0;
      seen_busy = 1'b0; got_blank = 1'b0; got_req = 1'b0;
      for (int i = 0; i < 4; i++) begin
         rise_t[i] = 0; fall_t[i] = 0; rise_f[i] = 0; fall_f[i] = 0; last_f[i] = 0;
      end
   endtask

   // One clock: advance TIME, then sample the outputs of the new cycle.
   task automatic cyc();
      @(posedge clk);
      #1;
      time_r = time_r + 64'd1;
      if (IMPULSE && !imp_q) begin
         if (n_rise < 4) begin rise_t[n_rise] = time_r; rise_f[n_rise] = NCO_FREQ; end
         n_rise++;
      end
      if (!IMPULSE && imp_q) begin
         if (n_fall < 4) begin
            fall_t[n_fall] = time_r; fall_f[n_fall] = NCO_FREQ; last_f[n_fall] = prev_f;
         end
         n_fall++;
      end
      if (BLANK && !got_blank) begin got_blank = 1'b1; first_blank_t = time_r; end
      if (REQ_COMM && !req_q && !got_req) begin got_req = 1'b1; req_first_t = time_r; end
      n_imp  += int'(IMPULSE);
      n_blk  += int'(BLANK);
      n_req  += int'(REQ_COMM);
      n_late += int'(ERR_LATE);
      n_ovr  += int'(OVERRUN);
      n_upd  += int'(NCO_UPDATE);
      if (BUSY) seen_busy = 1'b1;
      imp_q  = IMPULSE;
      blk_q  = BLANK;
      req_q  = REQ_COMM;
      prev_f = NCO_FREQ;
   endtask

   task automatic send(input cmd_t c);
      cmd = c;
      data_wr = 1'b1;
      cyc();
      data_wr = 1'b0;
      cyc();
   endtask

   task automatic wait_idle(input string tag, input int max);
      int n = 0;
      while (!(seen_busy && !BUSY && !REQ_COMM) && n < max) begin cyc(); n++; end
      check({tag, "_finish"}, 64'(n < max), 64'd1);
   endtask

   task automatic wait_rise(input string tag, input int k, input int max);
      int n = 0;
      while (n_rise < k && n < max) begin cyc(); n++; end
      check({tag, "_rise_wait"}, 64'(n < max), 64'd1);
   endtask

   task automatic wait_fall(input string tag, input int k, input int max);
      int n = 0;
      while (n_fall < k && n < max) begin cyc(); n++; end
      check({tag, "_fall_wait"}, 64'(n < max), 64'd1);
   endtask

   function automatic logic [63:0] all_outs();
      return {9'd0, REQ_COMM, IMPULSE, BLANK, NCO_FREQ, NCO_UPDATE, BUSY, ERR_LATE, OVERRUN};
   endfunction

   initial begin
      rst_n = 1'b0; abort = 1'b0; data_wr = 1'b0; time_r = 64'd0;
      imp_q = 1'b0; blk_q = 1'b0; req_q = 1'b0; prev_f = 48'd0;
      cmd = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      clear_stats();
      #1;
      check("reset_outputs", all_outs(), 64'd0);
      cyc(); cyc();
      rst_n = 1'b1;

      // priming request after reset
      clear_stats();
      for (int i = 0; i < 8; i++) cyc();
      check("prime_req_len", n_req, 4);
      check("prime_idle", 64'(seen_busy), 64'd0);

      // basic type 0 command
      clear_stats();
      time_r = 64'd1000;
      send(mk(48'd5, 0, 0, 64'd1100, 16'd3, TYPE_CONST, 32'd10, 32'd20, 32'd5, 32'd5));
      wait_idle("basic", 400);
      check("basic_blank_start", first_blank_t, 64'd1101);
      check("basic_blank_cycles", n_blk, 10);
      check("basic_pulse_count", n_rise, 3);
      check("basic_pulse_cycles", n_imp, 30);
      check("basic_rise0", rise_t[0], 64'd1106);
      check("basic_fall0", fall_t[0], 64'd1116);
      check("basic_rise1", rise_t[1], 64'd1136);
      check("basic_rise2", rise_t[2], 64'd1166);
      check("basic_fall2", fall_t[2], 64'd1176);
      check("basic_req_start", req_first_t, 64'd1182);
      check("basic_req_len", n_req, 4);
      check("basic_freq", NCO_FREQ, 64'd5);
      check("basic_no_late", n_late, 0);

      // late command
      clear_stats();
      time_r = 64'd2000;
      send(mk(48'd9, 0, 0, 64'd1500, 16'd3, TYPE_CONST, 32'd10, 32'd20, 32'd5, 32'd5));
      wait_idle("late", 100);
      check("late_err_pulse", n_late, 1);
      check("late_no_impulse", n_imp, 0);
      check("late_no_blank", n_blk, 0);
      check("late_req_len", n_req, 4);

      // per-pulse step
      clear_stats();
      time_r = 64'd3000;
      send(mk(48'd100, 48'd10, 0, 64'd3010, 16'd3, TYPE_STEP, 32'd4, 32'd3, 32'd2, 32'd2));
      wait_idle("step", 200);
      check("step_pulses", n_rise, 3);
      check("step_f0", rise_f[0], 64'd100);
      check("step_f1", rise_f[1], 64'd110);
      check("step_f2", rise_f[2], 64'd120);
      check("step_updates", n_upd, 3);

      // type 1 sweep (constant when the sweep is not built)
      clear_stats();
      time_r = 64'd4000;
      send(mk(48'd50, 48'd1, 32'd4, 64'd4010, 16'd2, TYPE_SWEEP, 32'd16, 32'd5, 32'd1, 32'd1));
      wait_idle("sweep", 200);
      check("sweep_pulses", n_rise, 2);
`ifdef CMD_EXEC_SWEEP_EN
      check("sweep_rise0", rise_f[0], 64'd50);
      check("sweep_last0", last_f[0], 64'd53);
      check("sweep_end0", fall_f[0], 64'd54);
      check("sweep_rise1", rise_f[1], 64'd50);
      check("sweep_end1", fall_f[1], 64'd54);
      check("sweep_updates", n_upd, 10);
`else
      check("sweep_rise0", rise_f[0], 64'd50);
      check("sweep_end0", fall_f[0], 64'd50);
      check("sweep_end1", fall_f[1], 64'd50);
      check("sweep_updates", n_upd, 1);
`endif

      // overrun: two commands while one is active, the later one runs
      clear_stats();
      time_r = 64'd5000;
      send(mk(48'd1, 0, 0, 64'd5010, 16'd1, TYPE_CONST, 32'd5, 32'd0, 32'd20, 32'd2));
      cyc(); cyc(); cyc();
      send(mk(48'd2, 0, 0, 64'd5200, 16'd1, TYPE_CONST, 32'd3, 32'd2, 32'd0, 32'd1));
      send(mk(48'd3, 0, 0, 64'd5200, 16'd2, TYPE_CONST, 32'd3, 32'd2, 32'd0, 32'd1));
      wait_idle("overrun", 400);
      check("overrun_pulse", n_ovr, 1);
      check("overrun_pulses", n_rise, 3);
      check("overrun_second_start", rise_t[1], 64'd5201);
      check("overrun_freq", NCO_FREQ, 64'd3);
      check("overrun_no_late", n_late, 0);

      // zero lengths: straight to BLANK2
      clear_stats();
      time_r = 64'd6000;
      send(mk(48'd4, 0, 0, 64'd6010, 16'd0, TYPE_CONST, 32'd5, 32'd5, 32'd0, 32'd3));
      wait_idle("zero", 100);
      check("zero_blank_start", first_blank_t, 64'd6011);
      check("zero_blank_cycles", n_blk, 3);
      check("zero_no_impulse", n_rise, 0);
      check("zero_req_start", req_first_t, 64'd6015);

      // abort during the second pulse, with a coincident DATA_WR
      clear_stats();
      time_r = 64'd7000;
      send(mk(48'd100, 48'd10, 0, 64'd7010, 16'd3, TYPE_STEP, 32'd10, 32'd5, 32'd2, 32'd2));
      wait_rise("abort", 2, 100);
      cyc(); cyc();
      check("abort_in_pulse", 64'(IMPULSE), 64'd1);
      clear_stats();
      cmd = mk(48'd7, 0, 0, 64'd7100, 16'd1, TYPE_CONST, 32'd3, 32'd3, 32'd3, 32'd3);
      abort = 1'b1;
      data_wr = 1'b1;
      cyc();
      check("abort_impulse_low", 64'(IMPULSE), 64'd0);
      check("abort_busy_low", 64'(BUSY), 64'd0);
      check("abort_blank_low", 64'(BLANK), 64'd0);
      check("abort_req_high", 64'(REQ_COMM), 64'd1);
      check("abort_freq_held", NCO_FREQ, 64'd110);
      abort = 1'b0;
      data_wr = 1'b0;
      for (int i = 0; i < 8; i++) cyc();
      check("abort_req_len", n_req, 4);
      check("abort_cmd_dropped", 64'(seen_busy), 64'd0);

      // asynchronous reset in the middle of a pause
      clear_stats();
      time_r = 64'd8000;
      send(mk(48'd77, 0, 0, 64'd8010, 16'd2, TYPE_CONST, 32'd5, 32'd10, 32'd2, 32'd2));
      wait_fall("reset", 1, 100);
      cyc(); cyc();
      check("pause_busy", 64'(BUSY), 64'd1);
      check("pause_freq", NCO_FREQ, 64'd77);
      #2;
      rst_n = 1'b0;
      #1;
      check("reset_mid_pause", all_outs(), 64'd0);
      cyc();
      rst_n = 1'b1;
      clear_stats();
      for (int i = 0; i < 8; i++) cyc();
      check("reprime_req_len", n_req, 4);
      check("reprime_idle", 64'(seen_busy), 64'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
